// File: rtl/fp_issue_seq_if.sv
// Issue/writeback bundle between the FP decode stage and the FP issue sequencer.
interface fp_issue_seq_if;
    logic       issue_valid;
    logic [4:0] funct5;
    logic [2:0] rm;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       stall;
    logic       illegal;
    logic [4:0] fpu_sel;
    logic       mc_start;
    logic       mc_op;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_mc;

    modport master (
        output issue_valid, funct5, rm, rd, rs1, rs2,
        input  stall, illegal, fpu_sel, mc_start, mc_op, wb_valid, wb_rd, wb_mc
    );

    modport slave (
        input  issue_valid, funct5, rm, rd, rs1, rs2,
        output stall, illegal, fpu_sel, mc_start, mc_op, wb_valid, wb_rd, wb_mc
    );
endinterface

// File: rtl/fp_issue_seq.sv
// FP issue sequencer: decodes FP ops, issues single-cycle ops freely and tracks one
// iterative FDIV/FSQRT with a pending-register scoreboard and a shared writeback port.
module fp_issue_seq #(
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 12,
    parameter int NREG     = 32
) (
    input logic          clk,
    input logic          rst_n,
    fp_issue_seq_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

    localparam logic [5:0] DIV_M1  = 6'(DIV_LAT - 1);
    localparam logic [5:0] SQRT_M1 = 6'(SQRT_LAT - 1);

    function automatic logic is_sc_f(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101,
            5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110: is_sc_f = 1'b1;
            default:                                          is_sc_f = 1'b0;
        endcase
    endfunction

    state_t            state_r, state_n;
    logic [5:0]        cnt_r, cnt_n;
    logic [NREG-1:0]   pending_r, pending_n;
    logic [4:0]        mc_rd_r;
    logic              illegal_r, mc_start_r, mc_op_r, wb_valid_r, wb_mc_r;
    logic [4:0]        fpu_sel_r, wb_rd_r;

    logic rm_ok_s, sc_s, mc_s, ill_s, hazard_s, busy_s, stall_s;
    logic acc_sc_s, acc_mc_s, acc_ill_s, done_next_s;

    // Decode, hazard detection and acceptance
    always_comb begin
        rm_ok_s     = (bus.rm != 3'b101) && (bus.rm != 3'b110);
        sc_s        = rm_ok_s && is_sc_f(bus.funct5);
        mc_s        = rm_ok_s && ((bus.funct5 == 5'b00011) || (bus.funct5 == 5'b01011));
        ill_s       = !sc_s && !mc_s;
        hazard_s    = pending_r[bus.rs1] | pending_r[bus.rs2] | pending_r[bus.rd];
        busy_s      = (state_r == ST_BUSY);
        // counter==1 means the iterative result owns the writeback port next cycle
        stall_s     = bus.issue_valid &&
                      (hazard_s || (mc_s && busy_s) || (sc_s && busy_s && (cnt_r == 6'd1)));
        acc_sc_s    = bus.issue_valid && !stall_s && sc_s;
        acc_mc_s    = bus.issue_valid && !stall_s && mc_s;
        acc_ill_s   = bus.issue_valid && !stall_s && ill_s;
        done_next_s = busy_s && (cnt_r == 6'd1);
    end

    // Next state, latency counter and scoreboard update
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        pending_n = pending_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (acc_mc_s) begin
                    state_n = ST_BUSY;
                    cnt_n   = (bus.funct5 == 5'b01011) ? SQRT_M1 : DIV_M1;
                end else begin
                    state_n = ST_IDLE;
                    cnt_n   = 6'd0;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 6'd1) begin
                    state_n = ST_DONE;
                    cnt_n   = 6'd0;
                end else begin
                    state_n = ST_BUSY;
                    cnt_n   = cnt_r - 6'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 6'd0;
            end
        endcase
        if (state_r == ST_DONE) begin
            pending_n[mc_rd_r] = 1'b0;
        end else begin
            pending_n = pending_n;
        end
        // applied last so a same-index set overrides the clear
        if (acc_mc_s) begin
            pending_n[bus.rd] = 1'b1;
        end else begin
            pending_n = pending_n;
        end
    end

    // State, counter and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            pending_r <= '0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            pending_r <= pending_n;
        end
    end

    // Registered issue and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r  <= 1'b0;
            mc_start_r <= 1'b0;
            mc_op_r    <= 1'b0;
            mc_rd_r    <= 5'd0;
            fpu_sel_r  <= 5'd0;
            wb_valid_r <= 1'b0;
            wb_mc_r    <= 1'b0;
            wb_rd_r    <= 5'd0;
        end else begin
            illegal_r  <= acc_ill_s;
            mc_start_r <= acc_mc_s;
            wb_valid_r <= acc_sc_s | done_next_s;
            wb_mc_r    <= done_next_s;
            if (acc_mc_s) begin
                mc_op_r <= (bus.funct5 == 5'b01011);
                mc_rd_r <= bus.rd;
            end
            if (acc_sc_s) begin
                fpu_sel_r <= bus.funct5;
                wb_rd_r   <= bus.rd;
            end else if (done_next_s) begin
                wb_rd_r   <= mc_rd_r;
            end
        end
    end

    assign bus.stall    = stall_s;
    assign bus.illegal  = illegal_r;
    assign bus.fpu_sel  = fpu_sel_r;
    assign bus.mc_start = mc_start_r;
    assign bus.mc_op    = mc_op_r;
    assign bus.wb_valid = wb_valid_r;
    assign bus.wb_rd    = wb_rd_r;
    assign bus.wb_mc    = wb_mc_r;
endmodule

// File: tb/tb_fp_issue_seq.sv
// Directed plus randomized bench for fp_issue_seq against a cycle-time reference model.
module tb_fp_issue_seq;
    localparam int DIV_LAT  = 8;
    localparam int SQRT_LAT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fp_issue_seq_if bus ();

    fp_issue_seq #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight iterative op described by absolute cycle numbers
    int         cyc;
    int         mc_acc;
    int         mc_done;
    logic [4:0] mc_rd_m;
    logic       mc_op_m;
    logic [31:0] pend_m;
    logic       e_wb_sc, e_ill, e_start;
    logic [4:0] e_wbrd_sc, e_sel;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; mc_acc = -100; mc_done = -1; mc_rd_m = 5'd0; mc_op_m = 1'b0;
        pend_m = 32'd0; e_wb_sc = 1'b0; e_ill = 1'b0; e_start = 1'b0;
        e_wbrd_sc = 5'd0; e_sel = 5'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    8'(bus.stall),    8'd0);
        check({tag, "_illegal"},  8'(bus.illegal),  8'd0);
        check({tag, "_fpu_sel"},  8'(bus.fpu_sel),  8'd0);
        check({tag, "_mc_start"}, 8'(bus.mc_start), 8'd0);
        check({tag, "_mc_op"},    8'(bus.mc_op),    8'd0);
        check({tag, "_wb_valid"}, 8'(bus.wb_valid), 8'd0);
        check({tag, "_wb_rd"},    8'(bus.wb_rd),    8'd0);
        check({tag, "_wb_mc"},    8'(bus.wb_mc),    8'd0);
    endtask

    // One cycle: drive at posedge+1, compare at negedge, advance the model at the edge
    task automatic step(input logic v, input logic [4:0] f, input logic [2:0] r,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        logic sc, mc, ill, exp_stall, acc, mc_wb;
        bus.issue_valid = v; bus.funct5 = f; bus.rm = r; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
        #4;
        sc  = (r != 3'b101) && (r != 3'b110) &&
              (f inside {5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101,
                         5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110});
        mc  = (r != 3'b101) && (r != 3'b110) && (f == 5'b00011 || f == 5'b01011);
        ill = !sc && !mc;
        exp_stall = v && (pend_m[s1] || pend_m[s2] || pend_m[d] ||
                          (mc && cyc < mc_done) || (sc && cyc == mc_done - 1));
        mc_wb = (cyc == mc_done);
        check("stall",    8'(bus.stall),    8'(exp_stall));
        check("wb_valid", 8'(bus.wb_valid), 8'(e_wb_sc || mc_wb));
        if (e_wb_sc || mc_wb) begin
            check("wb_mc", 8'(bus.wb_mc), 8'(mc_wb));
            check("wb_rd", 8'(bus.wb_rd), 8'(mc_wb ? mc_rd_m : e_wbrd_sc));
        end
        check("illegal",  8'(bus.illegal),  8'(e_ill));
        check("mc_start", 8'(bus.mc_start), 8'(e_start));
        check("fpu_sel",  8'(bus.fpu_sel),  8'(e_sel));
        if (cyc > mc_acc && cyc <= mc_done) check("mc_op", 8'(bus.mc_op), 8'(mc_op_m));

        acc     = v && !exp_stall;
        e_ill   = acc && ill;
        e_start = acc && mc;
        e_wb_sc = acc && sc;
        if (acc && sc) begin
            e_wbrd_sc = d;
            e_sel     = f;
        end
        if (mc_wb) pend_m[mc_rd_m] = 1'b0;
        if (acc && mc) begin
            pend_m[d] = 1'b1;
            mc_acc    = cyc;
            mc_done   = cyc + ((f == 5'b01011) ? SQRT_LAT : DIV_LAT);
            mc_rd_m   = d;
            mc_op_m   = (f == 5'b01011);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        logic [4:0] sc_tbl [10];
        logic [4:0] f, d, s1, s2;
        logic [2:0] r;
        int k;
        sc_tbl = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101,
                   5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110};
        bus.issue_valid = 1'b0; bus.funct5 = 5'd0; bus.rm = 3'd0;
        bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 rst_n = 1'b1;

        // back-to-back FADD, first one in the very first cycle after reset release
        step(1'b1, 5'b00000, 3'd0, 5'd3, 5'd1, 5'd2);
        step(1'b1, 5'b00000, 3'd0, 5'd4, 5'd1, 5'd2);
        idle(2);

        // FDIV rd=5, independent FADD at t+3, dependent FADD held until accepted
        step(1'b1, 5'b00011, 3'd0, 5'd5, 5'd1, 5'd2);
        idle(2);
        step(1'b1, 5'b00000, 3'd0, 5'd8, 5'd7, 5'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 5'b00000, 3'd0, 5'd9, 5'd5, 5'd1);
        idle(2);

        // FSQRT then FMUL offered on the writeback-collision cycle
        step(1'b1, 5'b01011, 3'd0, 5'd10, 5'd1, 5'd2);
        idle(10);
        step(1'b1, 5'b00010, 3'd0, 5'd11, 5'd1, 5'd2);
        step(1'b1, 5'b00010, 3'd0, 5'd11, 5'd1, 5'd2);
        idle(2);

        // FSQRT then FDIV offered from t+4 until it lands in DONE
        step(1'b1, 5'b01011, 3'd0, 5'd10, 5'd1, 5'd2);
        idle(3);
        for (int i = 0; i < 9; i++) step(1'b1, 5'b00011, 3'd0, 5'd12, 5'd1, 5'd2);
        idle(10);

        // undecodable ops
        step(1'b1, 5'b01111, 3'd0, 5'd13, 5'd1, 5'd2);
        step(1'b1, 5'b00000, 3'b101, 5'd14, 5'd1, 5'd2);
        step(1'b1, 5'b00011, 3'b110, 5'd15, 5'd1, 5'd2);
        step(1'b1, 5'b00000, 3'd0, 5'd16, 5'd15, 5'd14);
        idle(2);

        // reset during an FDIV
        step(1'b1, 5'b00011, 3'd0, 5'd6, 5'd1, 5'd2);
        idle(3);
        bus.issue_valid = 1'b1; bus.funct5 = 5'b00000; bus.rm = 3'd0;
        bus.rd = 5'd17; bus.rs1 = 5'd6; bus.rs2 = 5'd1;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        idle(10);
        step(1'b1, 5'b00000, 3'd0, 5'd17, 5'd6, 5'd6);
        idle(2);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 6)       f = sc_tbl[$urandom_range(0, 9)];
            else if (k == 6) f = 5'b00011;
            else if (k == 7) f = 5'b01011;
            else             f = 5'($urandom);
            r  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom);
            d  = {2'b00, 3'($urandom)};
            s1 = {2'b00, 3'($urandom)};
            s2 = {2'b00, 3'($urandom)};
            step(($urandom_range(0, 3) != 0), f, r, d, s1, s2);
        end
        idle(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
